// File: rtl/tinyml_cam_bbox_overlay_2ppc.sv
// Two-pixel-per-clock bounding-box outline overlay with a 4-entry skid FIFO
// and a registered valid/ready output stage.
module tinyml_cam_bbox_overlay_2ppc #(
   parameter int unsigned        P_DEPTH      = 8,
   parameter int unsigned        FRAME_WIDTH  = 1080,
   parameter int unsigned        FRAME_HEIGHT = 1080,
   parameter int unsigned        BOX_THICK    = 2,
   parameter logic [P_DEPTH-1:0] BOX_R        = 8'hFF,
   parameter logic [P_DEPTH-1:0] BOX_G        = 8'h00,
   parameter logic [P_DEPTH-1:0] BOX_B        = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*P_DEPTH-1:0] in_red,
   input  logic [2*P_DEPTH-1:0] in_green,
   input  logic [2*P_DEPTH-1:0] in_blue,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 box_en,
   input  logic [11:0]          box_x0,
   input  logic [11:0]          box_x1,
   input  logic [11:0]          box_y0,
   input  logic [11:0]          box_y1,
   output logic [2*P_DEPTH-1:0] out_red,
   output logic [2*P_DEPTH-1:0] out_green,
   output logic [2*P_DEPTH-1:0] out_blue,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sof,
   output logic                 out_eol,
   output logic                 overflow
);
   localparam int unsigned LW    = 2 * P_DEPTH;
   localparam int unsigned BEATS = FRAME_WIDTH / 2;
   localparam int unsigned BX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned Y_W   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int unsigned CW    = 13;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned LVW   = PW + 1;
   localparam logic [BX_W-1:0] BX_LAST = BX_W'(BEATS - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(FRAME_HEIGHT - 1);
   localparam logic [CW-1:0]   THICK   = CW'(BOX_THICK);

   typedef struct packed {
      logic [LW-1:0] r;
      logic [LW-1:0] g;
      logic [LW-1:0] b;
   } pix_t;

   pix_t            mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [LVW-1:0]  level, level_next;
   logic            push, pop, full;
   logic [BX_W-1:0] cnt_bx;
   logic [Y_W-1:0]  cnt_y;
   logic            last_beat;
   logic            sh_en;
   logic [11:0]     sh_x0, sh_x1, sh_y0, sh_y1;
   pix_t            head, ovl;
   logic [CW-1:0]   p_base, p, y13, x0, x1, y0, y1;
   logic            hit;

   // Full FIFO still accepts a beat when the same edge pops one.
   assign full       = (level == LVW'(DEPTH));
   assign pop        = (level != '0) && (!out_valid || out_ready);
   assign push       = in_valid && (!full || pop);
   assign level_next = level + LVW'(push) - LVW'(pop);
   assign last_beat  = (cnt_bx == BX_LAST) && (cnt_y == Y_LAST);

   assign p_base = CW'({cnt_bx, 1'b0});
   assign y13    = CW'(cnt_y);
   assign x0     = CW'(sh_x0);
   assign x1     = CW'(sh_x1);
   assign y0     = CW'(sh_y0);
   assign y1     = CW'(sh_y1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         in_ready <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         level    <= level_next;
         in_ready <= (level_next <= LVW'(1));
         if (in_valid && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_red, in_green, in_blue};
   end

   // Per-lane outline test; each lane only sees its own pixel column.
   always_comb begin
      head = mem[rd_ptr];
      ovl  = head;
      p    = '0;
      hit  = 1'b0;
      for (int l = 0; l < 2; l++) begin
         p   = p_base + CW'(l);
         hit = sh_en && (p >= x0) && (p <= x1) && (y13 >= y0) && (y13 <= y1) &&
               ((p < x0 + THICK) || (p + THICK > x1) ||
                (y13 < y0 + THICK) || (y13 + THICK > y1));
         if (hit) begin
            ovl.r[l*P_DEPTH +: P_DEPTH] = BOX_R;
            ovl.g[l*P_DEPTH +: P_DEPTH] = BOX_G;
            ovl.b[l*P_DEPTH +: P_DEPTH] = BOX_B;
         end
      end
   end

   // Raster position and per-frame box shadow, both stepped by pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_bx <= '0;
         cnt_y  <= '0;
         sh_en  <= 1'b0;
         sh_x0  <= '0;
         sh_x1  <= '0;
         sh_y0  <= '0;
         sh_y1  <= '0;
      end else if (pop) begin
         if (cnt_bx == BX_LAST) begin
            cnt_bx <= '0;
            cnt_y  <= (cnt_y == Y_LAST) ? '0 : cnt_y + Y_W'(1);
         end else begin
            cnt_bx <= cnt_bx + BX_W'(1);
         end
         if (last_beat) begin
            sh_en <= box_en;
            sh_x0 <= box_x0;
            sh_x1 <= box_x1;
            sh_y0 <= box_y0;
            sh_y1 <= box_y1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_red   <= '0;
         out_green <= '0;
         out_blue  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_red   <= ovl.r;
         out_green <= ovl.g;
         out_blue  <= ovl.b;
         out_sof   <= (cnt_bx == '0) && (cnt_y == '0);
         out_eol   <= (cnt_bx == BX_LAST);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tinyml_cam_bbox_overlay_2ppc.sv
// Randomized directed bench for the bbox overlay, scored against a queue-based
// behavioural model of the stream and outline rules.
module tb_tinyml_cam_bbox_overlay_2ppc;
   localparam int W     = 8;
   localparam int H     = 4;
   localparam int T     = 1;
   localparam int BEATS = W / 2;
   localparam int FB    = BEATS * H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] din = '0;
   logic [15:0] in_red, in_green, in_blue;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        box_en = 1'b0;
   logic [11:0] box_x0 = '0, box_x1 = '0, box_y0 = '0, box_y1 = '0;
   logic [15:0] out_red, out_green, out_blue;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sof, out_eol, overflow;

   assign in_red   = din[47:32];
   assign in_green = din[31:16];
   assign in_blue  = din[15:0];

   always #5 clk = ~clk;

   tinyml_cam_bbox_overlay_2ppc #(
      .P_DEPTH(8), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BOX_THICK(T),
      .BOX_R(8'hFF), .BOX_G(8'h00), .BOX_B(8'h00)
   ) dut (
      .clk(clk), .rst(rst),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .in_valid(in_valid), .in_ready(in_ready),
      .box_en(box_en), .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .overflow(overflow)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_checks = 0;

   // Behavioural model: accepted-beat queue, output slot, frame beat index, box shadow.
   logic [47:0] mq[$];
   logic [47:0] m_out;
   logic        m_ov, m_sof, m_eol, m_ovf, m_rdy;
   int          m_k;
   logic        sh_en;
   int          sh_x0, sh_x1, sh_y0, sh_y1;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] overlay(input logic [47:0] d, input int k);
      logic [47:0] o;
      int yy, p;
      o  = d;
      yy = k / BEATS;
      for (int l = 0; l < 2; l++) begin
         p = 2 * (k % BEATS) + l;
         if (sh_en && p >= sh_x0 && p <= sh_x1 && yy >= sh_y0 && yy <= sh_y1 &&
             (p < sh_x0 + T || p + T > sh_x1 || yy < sh_y0 + T || yy + T > sh_y1)) begin
            o[32 + 8*l +: 8] = 8'hFF;
            o[16 + 8*l +: 8] = 8'h00;
            o[8*l +: 8]      = 8'h00;
         end
      end
      return o;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_out = '0; m_ov = 1'b0; m_sof = 1'b0; m_eol = 1'b0; m_ovf = 1'b0; m_rdy = 1'b0;
      m_k = 0;
      sh_en = 1'b0; sh_x0 = 0; sh_x1 = 0; sh_y0 = 0; sh_y1 = 0;
   endtask

   task automatic model_step();
      logic [47:0] d;
      logic        do_pop;
      do_pop = (mq.size() > 0) && (!m_ov || out_ready);
      if (do_pop) begin
         d     = mq.pop_front();
         m_out = overlay(d, m_k);
         m_ov  = 1'b1;
         m_sof = (m_k == 0);
         m_eol = ((m_k % BEATS) == BEATS - 1);
         if (m_k == FB - 1) begin
            sh_en = box_en;
            sh_x0 = int'(box_x0); sh_x1 = int'(box_x1);
            sh_y0 = int'(box_y0); sh_y1 = int'(box_y1);
         end
         m_k = (m_k + 1) % FB;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (in_valid) begin
         if (mq.size() < 4) mq.push_back(din);
         else m_ovf = 1'b1;
      end
      m_rdy = (mq.size() <= 1);
   endtask

   task automatic compare();
      chk("out_valid", 48'(out_valid), 48'(m_ov));
      chk("in_ready",  48'(in_ready),  48'(m_rdy));
      chk("overflow",  48'(overflow),  48'(m_ovf));
      if (m_ov) begin
         chk("out_data", {out_red, out_green, out_blue}, m_out);
         chk("out_sof",  48'(out_sof), 48'(m_sof));
         chk("out_eol",  48'(out_eol), 48'(m_eol));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input logic v, input logic [47:0] d);
      in_valid = v;
      din      = d;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), $urandom};
   endfunction

   task automatic set_box(input logic en, input int a, input int b, input int c, input int d);
      box_en = en;
      box_x0 = 12'(a); box_x1 = 12'(b); box_y0 = 12'(c); box_y1 = 12'(d);
   endtask

   initial begin
      int grace, n_sent, n_out;
      logic v;
      model_reset();

      // Reset state.
      rst = 1'b1; out_ready = 1'b1; drive(1'b0, '0);
      repeat (2) cycle();
      chk("rst_out_data", {out_red, out_green, out_blue}, 48'h0);
      chk("rst_sof_eol", {46'h0, out_sof, out_eol}, 48'h0);
      rst = 1'b0;

      // Passthrough with outline disabled: two ramp frames.
      for (int i = 0; i < 2 * FB; i++) begin
         drive(1'b1, {8'(4*i+1), 8'(4*i), 8'(~(4*i+1)), 8'(~(4*i)), 8'(3*i+1), 8'(3*i)});
         cycle();
      end
      drive(1'b0, '0);
      repeat (3) cycle();

      // Full-height rows box, then a narrow-column box, two frames each.
      set_box(1'b1, 1, 6, 1, 2);
      for (int i = 0; i < 2 * FB; i++) begin drive(1'b1, rnd48()); cycle(); end
      set_box(1'b1, 2, 5, 0, 3);
      for (int i = 0; i < 2 * FB; i++) begin drive(1'b1, rnd48()); cycle(); end
      drive(1'b0, '0);
      repeat (3) cycle();

      // Random output stalls with an upstream that overshoots ready by 2 beats.
      grace = 0; n_sent = 0; n_out = 0;
      for (int c = 0; c < 300; c++) begin
         if (in_ready) begin
            grace = 2;
            v = ($urandom_range(0, 3) != 0);
         end else if (grace > 0) begin
            grace--;
            v = 1'b1;
         end else begin
            v = 1'b0;
         end
         drive(v, rnd48());
         if (v) n_sent++;
         out_ready = ($urandom_range(0, 1) == 1);
         if (out_valid && out_ready) n_out++;
         cycle();
      end
      drive(1'b0, '0);
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) n_out++;
         cycle();
      end
      chk("stall_beat_count", 48'(n_out), 48'(n_sent));
      chk("stall_no_overflow", 48'(overflow), 48'h0);

      // Upstream ignores ready while output is blocked behind one held beat.
      out_ready = 1'b0;
      drive(1'b1, rnd48());
      cycle();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, rnd48());
         cycle();
         chk("ovf_after_beat", 48'(overflow), 48'(i >= 4));
      end
      drive(1'b0, '0);
      out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) n_out++;
         cycle();
      end
      chk("ovf_emerged", 48'(n_out), 48'd5);

      // Mid-frame asynchronous reset.
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
      set_box(1'b0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin drive(1'b1, rnd48()); cycle(); end
      drive(1'b0, '0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outs",
          {out_red, out_green[15:2], out_valid, out_sof, out_eol, overflow, in_ready}, 48'h0);
      chk("async_rst_blue", 48'(out_blue), 48'h0);
      model_reset();
      cycle();
      rst = 1'b0;
      drive(1'b1, rnd48());
      cycle();
      drive(1'b0, '0);
      cycle();
      chk("post_rst_valid", 48'(out_valid), 48'h1);
      chk("post_rst_sof", 48'(out_sof), 48'h1);
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
